servo_sequencer: RTL and testbench
==================================

// Module: servo_sequencer
// PURPOSE
//  Plays back a three-axis servo trajectory stored in three parallel ROMs
//  (one ROM per servo channel) that share one address bus.
//  Steps the shared rom_address at a fixed rate and registers the three ROM words into position outputs.
//  Those position outputs feed the three PWM channels.
//  Supports start/stop, looping, a manual single-step mode and an in-ROM end-of-sequence marker.
// PARAMETERS
//  DATA_WIDTH    8      width of each ROM word and each position output
//  ADDR_WIDTH    8      ROM address width; last address = 2**ADDR_WIDTH-1
//  STEP_TICKS    500000 clk cycles per trajectory step (10 ms @ 50 MHz); must be >= 3
//  END_CODE      8'hFF  end marker: a row where all three words equal END_CODE ends the sequence
//  CENTER        8'h80  reset/idle position value on all axes
// PORTS
//  clk          in   1           system clock (MAX10_CLK1_50)
//  rst          in   1           asynchronous, active-high reset
//  start        in   1           level; sampled in IDLE or DONE: begin playback at address 0
//  stop         in   1           level; abort playback from any state
//  loop_en      in   1           1: wrap to address 0 after last address or end marker
//  step_mode    in   1           1: advance only on step_req rising edge instead of the timer
//  step_req     in   1           synchronized button level; rising edge detected internally
//  rom_address  out  ADDR_WIDTH  shared address to the three ROMs (asynchronous read)
//  rom_data_x   in   DATA_WIDTH  ROM word, channel x
//  rom_data_y   in   DATA_WIDTH  ROM word, channel y
//  rom_data_z   in   DATA_WIDTH  ROM word, channel z
//  pos_x        out  DATA_WIDTH  registered position, channel x
//  pos_y        out  DATA_WIDTH  registered position, channel y
//  pos_z        out  DATA_WIDTH  registered position, channel z
//  pos_valid    out  1           one-cycle pulse on the cycle after pos_* update
//  busy         out  1           high in LOAD, CAPTURE and HOLD
//  seq_done     out  1           high in DONE
// BEHAVIOUR
//  Reset values (asynchronous):
//  - rom_address=0; pos_x/y/z=CENTER; pos_valid=0; busy=0; seq_done=0
//  - FSM=IDLE; tick counter=0; step_req edge register=0
//  States:
//  - IDLE: rom_address held at 0. start -> LOAD.
//  - LOAD: exactly 1 cycle for the ROM to settle -> CAPTURE.
//  - CAPTURE: 1 cycle; samples rom_data_* at the closing edge.
//    - All three words == END_CODE: pos_* unchanged, no pos_valid. loop_en=1 -> addr=0, LOAD; loop_en=0 -> DONE.
//    - Otherwise: pos_* <= rom_data_*; pos_valid=1 for the next cycle -> HOLD.
//  - HOLD, step_mode=0: counts STEP_TICKS-2 cycles, then advances.
//    Row-to-row period is exactly STEP_TICKS cycles.
//  - HOLD, step_mode=1: timer frozen and cleared; waits for a step_req rising edge, then advances.
//  - Advance: addr != last -> addr+1, LOAD.
//    addr == last -> loop_en=1: addr=0, LOAD; loop_en=0: DONE (addr holds at last).
//  - DONE: pos_* hold their last value. start -> addr=0, LOAD.
//  Edge cases:
//  - stop in any state: next state IDLE, addr=0, pos_* hold, counter cleared. stop beats start.
//  - start while busy: ignored.
//  - step_mode toggled mid-HOLD: 1->0 restarts the timer from 0.
//  - loop_en is sampled only at the advance/end decision.
//  - Position width equals ROM width: no truncation or extension.
//  - Async reset mid-step: all outputs return to reset values immediately.
// TESTING  (sim params: ADDR_WIDTH=3, STEP_TICKS=5, ROM rows x=10*i, y=20+i, z=200-i)
//  - Reset, then start for 1 cycle: pos_x=0,pos_y=20,pos_z=200 with pos_valid 3 cycles after start;
//    each subsequent row exactly 5 cycles later; after row 7: seq_done=1, busy=0, rom_address=7.
//  - Same with loop_en=1: after row 7, the next pos_valid carries row 0 exactly 5 cycles later; never DONE.
//  - Row 3 = FF/FF/FF, loop_en=0: pos stays at row 2 (20,22,198), no pos_valid, seq_done=1 two cycles after row 3 LOAD.
//  - step_mode=1: pos holds at row 0 for 50 cycles; each step_req 0->1 edge yields exactly one new row;
//    a held-high step_req yields only one advance.
//  - stop asserted in HOLD at row 4: IDLE next cycle, rom_address=0, pos holds row 4 values;
//    start together with stop: stays IDLE.
//  - rst pulsed mid-HOLD: pos_*=8'h80, busy=0, rom_address=0 without waiting for a clock edge.

Source files
------------

// File: rtl/servo_sequencer_if.sv
// servo_sequencer_if: control, ROM bus and position outputs of the servo sequencer
//  start/stop/loop_en/step_mode/step_req  controller -> sequencer
//  rom_address                            sequencer -> ROMs
//  rom_data_x/y/z                         ROMs -> sequencer
//  pos_x/y/z, pos_valid, busy, seq_done   sequencer -> PWM and status
interface servo_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();
  logic start, stop, loop_en, step_mode, step_req;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_data_x, rom_data_y, rom_data_z;
  logic [DATA_WIDTH-1:0] pos_x, pos_y, pos_z;
  logic pos_valid, busy, seq_done;
  modport slave (
    input start, stop, loop_en, step_mode, step_req, rom_data_x, rom_data_y, rom_data_z,
    output rom_address, pos_x, pos_y, pos_z, pos_valid, busy, seq_done
  );
  modport master (
    output start, stop, loop_en, step_mode, step_req, rom_data_x, rom_data_y, rom_data_z,
    input rom_address, pos_x, pos_y, pos_z, pos_valid, busy, seq_done
  );
endinterface

// File: rtl/servo_sequencer.sv
// servo_sequencer: steps a shared ROM address and registers three servo positions per row
//  clk, rst  clock and asynchronous active-high reset
//  bus       servo_sequencer_if.slave: control inputs, ROM address/data, positions and status
module servo_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int STEP_TICKS = 500000,
  parameter logic [DATA_WIDTH-1:0] END_CODE = 8'hFF,
  parameter logic [DATA_WIDTH-1:0] CENTER = 8'h80
) (
  input logic clk,
  input logic rst,
  servo_sequencer_if.slave bus
);
  localparam int CW = $clog2(STEP_TICKS);
  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pos_x_q, pos_y_q, pos_z_q;
  logic valid_q, valid_d, step_q, load_pos, end_row, step_edge, advance, last;
  assign end_row = bus.rom_data_x == END_CODE && bus.rom_data_y == END_CODE && bus.rom_data_z == END_CODE;
  assign step_edge = bus.step_req & ~step_q;
  // HOLD lasts STEP_TICKS-2 cycles so LOAD+CAPTURE+HOLD spans exactly STEP_TICKS
  assign advance = bus.step_mode ? step_edge : cnt_q == CW'(STEP_TICKS - 3);
  assign last = &addr_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = '0;
    valid_d = 1'b0;
    load_pos = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      addr_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = bus.start ? LOAD : IDLE;
        LOAD: state_d = CAPTURE;
        CAPTURE: begin
          if (end_row) begin
            state_d = bus.loop_en ? LOAD : DONE;
            addr_d = bus.loop_en ? '0 : addr_q;
          end else begin
            load_pos = 1'b1;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            state_d = (!last || bus.loop_en) ? LOAD : DONE;
            addr_d = !last ? addr_q + 1'b1 : (bus.loop_en ? '0 : addr_q);
          end else cnt_d = bus.step_mode ? '0 : cnt_q + 1'b1;
        end
        DONE: begin
          state_d = bus.start ? LOAD : DONE;
          addr_d = bus.start ? '0 : addr_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      step_q <= 1'b0;
      pos_x_q <= CENTER;
      pos_y_q <= CENTER;
      pos_z_q <= CENTER;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      step_q <= bus.step_req;
      if (load_pos) begin
        pos_x_q <= bus.rom_data_x;
        pos_y_q <= bus.rom_data_y;
        pos_z_q <= bus.rom_data_z;
      end
    end
  end
  assign bus.rom_address = addr_q;
  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;
  assign bus.pos_z = pos_z_q;
  assign bus.pos_valid = valid_q;
  assign bus.busy = state_q == LOAD || state_q == CAPTURE || state_q == HOLD;
  assign bus.seq_done = state_q == DONE;
endmodule

// File: tb/tb_servo_sequencer.sv
// tb_servo_sequencer: scoreboard bench for servo_sequencer with an 8-row trajectory ROM
module tb_servo_sequencer;
  logic clk = 0, rst = 0;
  int cyc = 0, n_chk = 0, n_fail = 0, end_row = -1;
  typedef struct {int x; int y; int z; int c;} exp_t;
  exp_t sb[$];
  servo_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  servo_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .STEP_TICKS(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    bus.rom_data_x = int'(bus.rom_address) == end_row ? 8'hFF : 8'(10 * int'(bus.rom_address));
    bus.rom_data_y = int'(bus.rom_address) == end_row ? 8'hFF : 8'(20 + int'(bus.rom_address));
    bus.rom_data_z = int'(bus.rom_address) == end_row ? 8'hFF : 8'(200 - int'(bus.rom_address));
  end
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(int k, int c);
    exp_t e;
    e.x = 10 * (k % 8);
    e.y = 20 + k % 8;
    e.z = 200 - k % 8;
    e.c = c;
    sb.push_back(e);
  endtask
  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic pulse_start(output int s);
    @(negedge clk);
    bus.start = 1;
    s = cyc;
    @(negedge clk);
    bus.start = 0;
  endtask
  task automatic check_pos(string tag, int x, int y, int z);
    check({tag, "_x"}, int'(bus.pos_x), x);
    check({tag, "_y"}, int'(bus.pos_y), y);
    check({tag, "_z"}, int'(bus.pos_z), z);
  endtask
  always @(negedge clk) begin
    if (bus.pos_valid) begin
      exp_t e;
      if (sb.size() == 0) check("unexpected_valid", cyc, -1);
      else begin
        e = sb.pop_front();
        check("row", int'(bus.pos_x), e.x);
        check("row_y", int'(bus.pos_y), e.y);
        check("row_z", int'(bus.pos_z), e.z);
        check("row_cycle", cyc, e.c);
      end
    end
  end
  initial begin
    int s, c, d;
    bus.start = 0;
    bus.stop = 0;
    bus.loop_en = 0;
    bus.step_mode = 0;
    bus.step_req = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check_pos("reset_pos", 128, 128, 128);
    check("reset_valid", int'(bus.pos_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.seq_done), 0);
    check("reset_addr", int'(bus.rom_address), 0);
    rst = 0;
    pulse_start(s);
    for (int k = 0; k < 8; k++) push(k, s + 3 + 5 * k);
    wait_cyc(s + 40);
    check("once_busy_before_done", int'(bus.busy), 1);
    wait_cyc(s + 41);
    check("once_done", int'(bus.seq_done), 1);
    check("once_busy", int'(bus.busy), 0);
    check("once_addr", int'(bus.rom_address), 7);
    check("once_sb_empty", sb.size(), 0);
    bus.loop_en = 1;
    pulse_start(s);
    for (int k = 0; k < 10; k++) push(k, s + 3 + 5 * k);
    wait_cyc(s + 50);
    check("loop_done", int'(bus.seq_done), 0);
    check("loop_busy", int'(bus.busy), 1);
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    bus.loop_en = 0;
    check("loop_stop_busy", int'(bus.busy), 0);
    check("loop_stop_addr", int'(bus.rom_address), 0);
    check_pos("loop_stop_pos", 10, 21, 199);
    check("loop_sb_empty", sb.size(), 0);
    end_row = 3;
    pulse_start(s);
    for (int k = 0; k < 3; k++) push(k, s + 3 + 5 * k);
    wait_cyc(s + 17);
    check("end_done_early", int'(bus.seq_done), 0);
    wait_cyc(s + 18);
    check("end_done", int'(bus.seq_done), 1);
    check("end_addr", int'(bus.rom_address), 3);
    check_pos("end_pos", 20, 22, 198);
    check("end_sb_empty", sb.size(), 0);
    end_row = -1;
    bus.step_mode = 1;
    pulse_start(s);
    push(0, s + 3);
    wait_cyc(s + 53);
    check_pos("step_hold", 0, 20, 200);
    bus.step_req = 1;
    c = cyc;
    push(1, c + 3);
    repeat (20) @(negedge clk);
    check_pos("step_held_high", 10, 21, 199);
    bus.step_req = 0;
    @(negedge clk);
    bus.step_req = 1;
    c = cyc;
    push(2, c + 3);
    @(negedge clk);
    bus.step_req = 0;
    wait_cyc(c + 6);
    bus.step_mode = 0;
    d = cyc;
    for (int k = 3; k < 8; k++) push(k, d + 5 + 5 * (k - 3));
    wait_cyc(d + 28);
    check("step_timer_done", int'(bus.seq_done), 1);
    check("step_sb_empty", sb.size(), 0);
    pulse_start(s);
    for (int k = 0; k < 5; k++) push(k, s + 3 + 5 * k);
    wait_cyc(s + 24);
    bus.stop = 1;
    bus.start = 1;
    @(negedge clk);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_addr", int'(bus.rom_address), 0);
    check("stop_done", int'(bus.seq_done), 0);
    check_pos("stop_pos", 40, 24, 196);
    @(negedge clk);
    check("stop_start_busy", int'(bus.busy), 0);
    bus.stop = 0;
    bus.start = 0;
    @(negedge clk);
    check("stop_idle_busy", int'(bus.busy), 0);
    check("stop_sb_empty", sb.size(), 0);
    pulse_start(s);
    push(0, s + 3);
    wait_cyc(s + 4);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1;
    #1;
    check_pos("arst_pos", 128, 128, 128);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_addr", int'(bus.rom_address), 0);
    check("arst_valid", int'(bus.pos_valid), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
